// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions: receiver state encoding, default baud
//            divisor (common with the transmitter) and data width.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default clock cycles per bit period, shared by uart_tx and uart_rx.
    localparam int DEFAULT_CLKS_PER_BIT = 2813;

    // Payload bits per frame.
    localparam int DATA_BITS = 8;

    // Receiver frame states. PARITY is only reachable in the 8E1 build.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync
// Brief    : Parameterised metastability flop chain for one asynchronous
//            input. Resets to 1 so an idle-high line never looks active.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    // Reject chains too short to resolve metastability.
    if (STAGES < 2) begin : g_bad_stages
        $error("uart_sync: STAGES must be >= 2");
    end

    // Shift the raw input through the chain; the last stage is the safe copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with valid/ready byte output, frame-error and
//            overrun pulses. Define UART_RX_PARITY_EN to receive 8E1 frames
//            and report parity mismatches on parity_err.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    // Baud counter sizing and the two sample points within a bit period.
    localparam int               c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam int               c_half      = CLKS_PER_BIT / 2;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_mid  = c_cnt_w'(c_half - 1);
    localparam logic [2:0]       c_bit_last  = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                 w_rx_s;

    uart_state_t          r_state;
    uart_state_t          w_state_nx;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nx;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_nx;
    logic [DATA_BITS-1:0] r_shift;

    logic                 w_shift_en;
    logic                 w_stop_ok;
    logic                 w_stop_bad;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

`ifdef UART_RX_PARITY_EN
    logic                 w_par_en;
    logic                 r_par_bit;
    logic                 r_parity_err;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------

    // State, baud counter and bit index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
        end
    end

    // Next-state logic: start-bit qualification at mid-bit, then one sample
    // per full bit period so every later sample also lands mid-bit.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + c_cnt_w'(1);
        w_bit_nx   = r_bit;
        w_shift_en = 1'b0;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (!w_rx_s) begin
                    w_state_nx = START;
                end
            end
            START: begin
                if (r_cnt == c_cnt_mid) begin
                    w_cnt_nx = '0;
                    w_bit_nx = '0;
                    // A line that is high again at mid-bit was only a glitch.
                    w_state_nx = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nx   = '0;
                    w_shift_en = 1'b1;
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nx = PARITY;
`else
                        w_state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nx   = '0;
                    w_par_en   = 1'b1;
                    w_state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nx = '0;
                    if (w_rx_s) begin
                        w_stop_ok  = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_stop_bad = 1'b1;
                        w_state_nx = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here until the line idles so a long low level
                // reports a single frame error.
                w_cnt_nx = '0;
                if (w_rx_s) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = IDLE;
            end
        endcase
    end

    // Data shift register, filled LSB-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Output register and status pulses
    // ------------------------------------------------------------------

    // Publish on a good stop bit; a pending byte is only replaced when it is
    // being taken in the same cycle, otherwise the new byte is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_stop_ok) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Capture the parity bit and flag an odd total on a well-framed byte;
    // a bad stop bit suppresses the parity report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_en) begin
                r_par_bit <= w_rx_s;
            end
            r_parity_err <= w_stop_ok && (^{r_shift, r_par_bit});
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx at CLKS_PER_BIT=16. Define
//            UART_RX_PARITY_EN to exercise the 8E1 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int C    = 16;
    localparam int H    = C / 2;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    // Cycles from the start edge to rx_valid rising.
    localparam int LAT = SYNC + H + (9 + EXTRA) * C + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx #(
        .CLKS_PER_BIT (C),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Event recorder, sampled mid-low-phase of the clock.
    int         rise_n = 0;
    int         last_rise = 0;
    int         valid_n = 0;
    int         fe_n = 0;
    int         ov_n = 0;
    int         pe_n = 0;
    logic       prev_v = 1'b0;
    logic [7:0] acc_q[$];

    always begin
        @(negedge clk);
        #1;
        if (rx_valid && !prev_v) begin
            rise_n++;
            last_rise = cyc;
        end
        if (rx_valid) valid_n++;
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        if (frame_err) fe_n++;
        if (overrun) ov_n++;
        if (parity_err) pe_n++;
        prev_v = rx_valid;
    end

    int g_start = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(C);
    endtask

    // Serial frame from the line's point of view: start, data LSB first,
    // optional even parity (inverted when par_ok=0), stop.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
        g_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ ~par_ok);
`else
        if (par_ok === 1'bx) drive_bit(1'b1);
`endif
        drive_bit(stop_b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        total++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_out: valid=%b data=%h, want 0/00", rx_valid, rx_data);
        end
        total++;
        if ({frame_err, overrun, parity_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, parity_err});
        end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_basic();
        int a0, r0, v0, f0, o0, p0;
        rx_ready = 1'b1;
        a0 = acc_q.size(); r0 = rise_n; v0 = valid_n; f0 = fe_n; o0 = ov_n; p0 = pe_n;
        send_frame(8'hA5, 1'b1, 1'b1);
        tick(4);
        total++;
        if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'hA5) begin
            bad++;
            $display("FAIL basic_data: count=%0d last=%h want 1 byte A5", acc_q.size() - a0,
                     acc_q.size() > 0 ? acc_q[acc_q.size()-1] : 8'h00);
        end
        total++;
        if (last_rise - g_start != LAT || rise_n != r0 + 1) begin
            bad++;
            $display("FAIL basic_latency: got %0d want %0d", last_rise - g_start, LAT);
        end
        total++;
        if (valid_n - v0 != 1) begin
            bad++;
            $display("FAIL basic_valid_width: got %0d want 1", valid_n - v0);
        end
        total++;
        if (fe_n != f0 || ov_n != o0 || pe_n != p0) begin
            bad++;
            $display("FAIL basic_flags: fe=%0d ov=%0d pe=%0d want 0", fe_n - f0, ov_n - o0, pe_n - p0);
        end
    endtask

    task automatic test_glitch();
        int a0, r0, f0, o0;
        a0 = acc_q.size(); r0 = rise_n; f0 = fe_n; o0 = ov_n;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2 * C);
        total++;
        if (rise_n != r0 || fe_n != f0 || ov_n != o0) begin
            bad++;
            $display("FAIL glitch_ignored: rises=%0d fe=%0d ov=%0d want 0", rise_n - r0, fe_n - f0, ov_n - o0);
        end
        send_frame(8'h3C, 1'b1, 1'b1);
        tick(4);
        total++;
        if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'h3C) begin
            bad++;
            $display("FAIL glitch_next: count=%0d want 1 byte 3C", acc_q.size() - a0);
        end
    endtask

    task automatic test_break();
        int a0, r0, f0;
        a0 = acc_q.size(); r0 = rise_n; f0 = fe_n;
        send_frame(8'h55, 1'b0, 1'b1);
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(C);
        total++;
        if (fe_n - f0 != 1) begin
            bad++;
            $display("FAIL break_frame_err: pulses=%0d want 1", fe_n - f0);
        end
        total++;
        if (rise_n != r0) begin
            bad++;
            $display("FAIL break_no_valid: rises=%0d want 0", rise_n - r0);
        end
        send_frame(8'h81, 1'b1, 1'b1);
        tick(4);
        total++;
        if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'h81) begin
            bad++;
            $display("FAIL break_recover: count=%0d want 1 byte 81", acc_q.size() - a0);
        end
    endtask

    task automatic test_overrun();
        int a0, o0;
        a0 = acc_q.size(); o0 = ov_n;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        tick(2);
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            bad++;
            $display("FAIL overrun_hold: valid=%b data=%h want 1/11", rx_valid, rx_data);
        end
        total++;
        if (ov_n - o0 != 1) begin
            bad++;
            $display("FAIL overrun_pulse: pulses=%0d want 1", ov_n - o0);
        end
        rx_ready = 1'b1;
        tick(2);
        total++;
        if (rx_valid !== 1'b0 || acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'h11) begin
            bad++;
            $display("FAIL overrun_drain: valid=%b taken=%0d want 0 and one byte 11", rx_valid, acc_q.size() - a0);
        end
    endtask

    task automatic test_back_to_back();
        int o0, s;
        o0 = ov_n;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        s = cyc;
        fork
            send_frame(8'h22, 1'b1, 1'b1);
            begin
                tick(LAT - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        tick(2);
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
            bad++;
            $display("FAIL b2b_replace: valid=%b data=%h want 1/22 (start %0d)", rx_valid, rx_data, s);
        end
        total++;
        if (ov_n != o0) begin
            bad++;
            $display("FAIL b2b_no_overrun: pulses=%0d want 0", ov_n - o0);
        end
        rx_ready = 1'b1;
        tick(2);
        total++;
        if (rx_valid !== 1'b0 || acc_q[acc_q.size()-1] !== 8'h22) begin
            bad++;
            $display("FAIL b2b_drain: valid=%b last=%h want 0/22", rx_valid, acc_q[acc_q.size()-1]);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        int a0, gap;
        rx_ready = 1'b1;
        a0 = acc_q.size();
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            gap = $urandom_range(0, 20);
            tick(gap);
            send_frame(d, 1'b1, 1'b1);
            exp_q.push_back(d);
        end
        tick(4);
        total++;
        if (acc_q.size() - a0 != exp_q.size()) begin
            bad++;
            $display("FAIL random_count: got %0d want %0d", acc_q.size() - a0, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (acc_q[a0 + k] !== exp_q[k]) begin
                    bad++;
                    $display("FAIL random_byte%0d: got %h want %h", k, acc_q[a0 + k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int a0, r0;
        a0 = acc_q.size(); r0 = rise_n;
        fork
            send_frame(8'hF0, 1'b1, 1'b1);
            begin
                tick(5 * C + 8);
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
        join
        tick(4);
        total++;
        if (rise_n != r0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_abort: rises=%0d valid=%b data=%h want 0/0/00", rise_n - r0, rx_valid, rx_data);
        end
        send_frame(8'h0F, 1'b1, 1'b1);
        tick(4);
        total++;
        if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'h0F) begin
            bad++;
            $display("FAIL reset_next: count=%0d want 1 byte 0F", acc_q.size() - a0);
        end
    endtask

    task automatic test_parity();
        int a0, p0, f0;
        a0 = acc_q.size(); p0 = pe_n; f0 = fe_n;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        tick(4);
        total++;
        if (pe_n - p0 != 1 || acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'h07) begin
            bad++;
            $display("FAIL parity_bad: pe=%0d taken=%0d want 1 and byte 07", pe_n - p0, acc_q.size() - a0);
        end
        p0 = pe_n;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b1;
        tick(C);
        total++;
        if (pe_n != p0 || fe_n - f0 != 1) begin
            bad++;
            $display("FAIL parity_frame_prec: pe=%0d fe=%0d want 0/1", pe_n - p0, fe_n - f0);
        end
`else
        total++;
        if (pe_n != 0 || parity_err !== 1'b0) begin
            bad++;
            $display("FAIL parity_tied: pulses=%0d want 0", pe_n);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
